// File: rtl/aes_pkg.sv
// Shared AES-128 types, constant tables and GF(2^8) helpers for the inverse cipher.
// Byte 0 sits in bits [127:120]; bytes run column-major (byte r+4c is row r, column c).
package aes_pkg;

   typedef logic [127:0] aes_block_t;

   typedef enum logic [2:0] {
      IDLE,
      KEY_EXP,
      READY,
      ROUND,
      FINAL
   } dec_fsm_t;

   localparam int NR = 10;

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
              gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
              gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
              gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
   endfunction

   // Row r rotates right by r columns.
   function automatic aes_block_t inv_shift_rows(input aes_block_t s);
      aes_block_t r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c-row+4)%4)) -: 8];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the last round.
module aes_inv_round
   import aes_pkg::*;
(
   input  aes_block_t s_in,
   input  aes_block_t rk,
   input  logic       last,
   output aes_block_t s_out
);

   aes_block_t sr;
   aes_block_t ark;

   always_comb begin
      sr  = inv_shift_rows(s_in);
      ark = '0;
      for (int i = 0; i < 16; i++) begin
         ark[127-8*i -: 8] = INV_SBOX[sr[127-8*i -: 8]] ^ rk[127-8*i -: 8];
      end
      s_out = ark;
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            s_out[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
         end
      end
   end

endmodule

// File: rtl/key_expansion.sv
// One forward AES-128 key schedule step: round key i-1 plus RCON[i] gives round key i.
module key_expansion
   import aes_pkg::*;
(
   input  logic [127:0] rk_in,
   input  logic [7:0]   rcon,
   output logic [127:0] rk_out
);

   logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = rk_in;
   assign temp = {SBOX[w3[23:16]] ^ rcon, SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};
   assign n0 = w0 ^ temp;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;
   assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/decrypt_engine.sv
// AES-128 inverse cipher: forward key expansion into rk[0..10], then one inverse round per clock.
// Build option AES_DEC_ZEROIZE_EN: halt in any non-IDLE state wipes keys, state and output.
module decrypt_engine #(
   parameter int NR     = 10,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              set_key,
   input  logic              halt,
   input  logic [DATA_W-1:0] state,
   input  logic [DATA_W-1:0] key,
   output logic [DATA_W-1:0] out,
   output logic              out_valid,
   output logic              key_ready,
   output logic              busy
);
   import aes_pkg::*;

   if (NR != 10 || DATA_W != 128) begin : g_bad_cfg
      $error("decrypt_engine supports only NR=10 and DATA_W=128");
   end

   dec_fsm_t   fsm_state, next_state;
   aes_block_t rk [0:10];
   aes_block_t s_reg, pend_ct, rk_prev, rk_step, rk_round, round_out;
   logic [7:0] rcon;
   logic [3:0] kcnt, rcnt;
   logic       pending;
   logic       accept_key, launch, zeroize;

`ifdef AES_DEC_ZEROIZE_EN
   assign zeroize = halt && (fsm_state != IDLE);
`else
   assign zeroize = 1'b0;
`endif

   assign accept_key = set_key && !halt && (fsm_state == IDLE || fsm_state == READY);
   // A start latched alongside set_key launches from READY one edge after expansion ends.
   assign launch     = (fsm_state == READY) && !halt && !set_key && (start || pending);
   assign rk_round   = rk[rcnt];

   always_comb begin
      rk_prev = rk[0];
      rcon    = 8'h00;
      if (kcnt >= 4'd1 && kcnt <= 4'd10) begin
         rk_prev = rk[kcnt - 4'd1];
         rcon    = RCON[kcnt];
      end
   end

   key_expansion u_key_exp (
      .rk_in  (rk_prev),
      .rcon   (rcon),
      .rk_out (rk_step)
   );

   aes_inv_round u_inv_round (
      .s_in  (s_reg),
      .rk    (rk_round),
      .last  (fsm_state == FINAL),
      .s_out (round_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fsm_state <= IDLE;
      else     fsm_state <= next_state;
   end

   always_comb begin
      next_state = fsm_state;
      unique case (fsm_state)
         IDLE:    if (accept_key) next_state = KEY_EXP;
         KEY_EXP: begin
            if (halt)               next_state = IDLE;
            else if (kcnt == 4'd10) next_state = READY;
         end
         READY: begin
            if (accept_key)  next_state = KEY_EXP;
            else if (launch) next_state = ROUND;
         end
         ROUND: begin
            if (halt)              next_state = READY;
            else if (rcnt == 4'd1) next_state = FINAL;
         end
         FINAL:   next_state = READY;
         default: next_state = IDLE;
      endcase
      if (zeroize) next_state = IDLE;
   end

   always_comb begin
      busy = (fsm_state == KEY_EXP) || (fsm_state == ROUND) || (fsm_state == FINAL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= 10; i++) rk[i] <= '0;
         s_reg     <= '0;
         pend_ct   <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         key_ready <= 1'b0;
         pending   <= 1'b0;
         kcnt      <= 4'd0;
         rcnt      <= 4'd0;
      end else begin
         out_valid <= 1'b0;
         if (zeroize) begin
            for (int i = 0; i <= 10; i++) rk[i] <= '0;
            s_reg     <= '0;
            out       <= '0;
            key_ready <= 1'b0;
            pending   <= 1'b0;
         end else begin
            if (accept_key) begin
               rk[0]     <= key;
               key_ready <= 1'b0;
               kcnt      <= 4'd1;
               if (start) begin
                  pending <= 1'b1;
                  pend_ct <= state;
               end
            end else if (fsm_state == KEY_EXP) begin
               if (halt) begin
                  pending   <= 1'b0;
                  key_ready <= 1'b0;
               end else begin
                  rk[kcnt] <= rk_step;
                  kcnt     <= kcnt + 4'd1;
                  if (kcnt == 4'd10) key_ready <= 1'b1;
               end
            end
            if (launch) begin
               s_reg   <= (pending ? pend_ct : state) ^ rk[10];
               rcnt    <= 4'd9;
               pending <= 1'b0;
            end
            if (fsm_state == ROUND && !halt) begin
               s_reg <= round_out;
               rcnt  <= rcnt - 4'd1;
            end
            if (fsm_state == FINAL && !halt) begin
               out       <= round_out;
               out_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_decrypt_engine.sv
// Scoreboard bench for decrypt_engine: a forward AES model builds ciphertexts, the monitor
// checks each out_valid against the queued plaintext. Honors AES_DEC_ZEROIZE_EN.
module tb_decrypt_engine;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   logic         clk = 1'b0;
   logic         rst;
   logic         start, set_key, halt;
   logic [127:0] state, key, out;
   logic         out_valid, key_ready, busy;

   int           errors = 0;
   int           checks = 0;
   int           edge_n = 0;
   int           valid_count = 0;
   int           last_valid_edge = -1;
   logic [127:0] exp_q [$];
   logic [7:0]   sbox_m [256];

   decrypt_engine dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .set_key   (set_key),
      .halt      (halt),
      .state     (state),
      .key       (key),
      .out       (out),
      .out_valid (out_valid),
      .key_ready (key_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every out_valid pulse consumes one expected plaintext.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         valid_count++;
         last_valid_edge = edge_n;
         if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 128'd1, 128'd0);
         end else begin
            check("out", out, exp_q.pop_front());
         end
      end
   end

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse then the affine map.
   task automatic build_sbox();
      logic [7:0] b;
      for (int x = 0; x < 256; x++) begin
         b = 8'h00;
         for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) b = 8'(y);
         sbox_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] model_encrypt(input logic [127:0] k, input logic [127:0] pt);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  s [16];
      logic [7:0]  t [16];
      logic [7:0]  rc;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox_m[tmp[23:16]] ^ rc, sbox_m[tmp[15:8]], sbox_m[tmp[7:0]], sbox_m[tmp[31:24]]};
            rc = gm(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = sbox_m[s[r+4*((c+r)%4)]];
         for (int c = 0; c < 4; c++) begin
            if (rd < 10) begin
               s[4*c]   = gm(t[4*c], 8'h02) ^ gm(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 8'h02) ^ gm(t[4*c+2], 8'h03) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 8'h02) ^ gm(t[4*c+3], 8'h03);
               s[4*c+3] = gm(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 8'h02);
            end else begin
               for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   task automatic wait_valid(input int target, input int budget);
      int n;
      n = 0;
      while (valid_count < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("wait_out_valid", 128'(valid_count >= target), 128'd1);
   endtask

   task automatic load_key(input logic [127:0] k);
      int n;
      @(negedge clk);
      key = k;
      set_key = 1'b1;
      @(negedge clk);
      set_key = 1'b0;
      n = 0;
      while (!key_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("load_key_ready", 128'(key_ready), 128'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout edge=%0d required=finish", edge_n);
      $fatal(1, "timeout");
   end

   initial begin
      int k_edge, s_edge, vc0;
      logic all_busy;
      logic [127:0] rk_or, rkey, pt;

      rst = 1'b1;
      start = 1'b0;
      set_key = 1'b0;
      halt = 1'b0;
      state = '0;
      key = '0;
      build_sbox();
      repeat (3) @(negedge clk);
      check("reset_out", out, 128'd0);
      check("reset_out_valid", 128'(out_valid), 128'd0);
      check("reset_key_ready", 128'(key_ready), 128'd0);
      check("reset_busy", 128'(busy), 128'd0);
      rst = 1'b0;

      // FIPS-197 C.1 with separate set_key and start
      @(negedge clk);
      key = C1_KEY;
      set_key = 1'b1;
      @(negedge clk);
      set_key = 1'b0;
      k_edge = edge_n;
      check("keyexp_busy", 128'(busy), 128'd1);
      repeat (9) @(negedge clk);
      check("key_ready_k9", 128'(key_ready), 128'd0);
      @(negedge clk);
      check("key_ready_k10", 128'(key_ready), 128'd1);
      check("key_ready_edge", 128'(edge_n - k_edge), 128'd10);
      state = C1_CT;
      start = 1'b1;
      exp_q.push_back(C1_PT);
      vc0 = valid_count;
      @(negedge clk);
      start = 1'b0;
      s_edge = edge_n;
      wait_valid(vc0 + 1, 20);
      check("c1_latency", 128'(last_valid_edge - s_edge), 128'd10);
      @(negedge clk);
      check("c1_pulse_width", 128'(out_valid), 128'd0);
      check("c1_out_hold", out, C1_PT);

      // FIPS-197 App. B with set_key and start together
      @(negedge clk);
      key = B_KEY;
      state = B_CT;
      set_key = 1'b1;
      start = 1'b1;
      exp_q.push_back(B_PT);
      vc0 = valid_count;
      @(negedge clk);
      set_key = 1'b0;
      start = 1'b0;
      k_edge = edge_n;
      repeat (9) @(negedge clk);
      check("b_key_ready_k9", 128'(key_ready), 128'd0);
      @(negedge clk);
      check("b_key_ready_k10", 128'(key_ready), 128'd1);
      wait_valid(vc0 + 1, 20);
      check("b_latency", 128'(last_valid_edge - k_edge), 128'd21);

      // halt at round 5
      load_key(C1_KEY);
      @(negedge clk);
      state = C1_CT;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vc0 = valid_count;
      repeat (4) @(negedge clk);
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      repeat (15) @(negedge clk);
      check("halt_no_valid", 128'(valid_count - vc0), 128'd0);
      check("halt_busy", 128'(busy), 128'd0);
`ifdef AES_DEC_ZEROIZE_EN
      check("zeroize_key_ready", 128'(key_ready), 128'd0);
      rk_or = '0;
      for (int i = 0; i <= 10; i++) rk_or |= dut.rk[i];
      check("zeroize_rk", rk_or, 128'd0);
      check("zeroize_out", out, 128'd0);
      state = C1_CT;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (15) @(negedge clk);
      check("zeroize_start_ignored", 128'(valid_count - vc0), 128'd0);
`else
      check("halt_key_ready", 128'(key_ready), 128'd1);
      state = C1_CT;
      start = 1'b1;
      exp_q.push_back(C1_PT);
      @(negedge clk);
      start = 1'b0;
      wait_valid(vc0 + 1, 20);
`endif

      // start held every cycle while a block is in flight
      load_key(C1_KEY);
      @(negedge clk);
      state = C1_CT;
      start = 1'b1;
      exp_q.push_back(C1_PT);
      vc0 = valid_count;
      @(negedge clk);
      all_busy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         all_busy &= busy;
         state = {$urandom(), $urandom(), $urandom(), $urandom()};
         @(negedge clk);
      end
      start = 1'b0;
      repeat (15) @(negedge clk);
      check("start_spam_busy", 128'(all_busy), 128'd1);
      check("start_spam_one_valid", 128'(valid_count - vc0), 128'd1);

      // rst during key expansion
      @(negedge clk);
      key = C1_KEY;
      set_key = 1'b1;
      @(negedge clk);
      set_key = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_kexp_out", out, 128'd0);
      check("rst_kexp_flags", 128'({out_valid, key_ready, busy}), 128'd0);
      @(negedge clk);
      rst = 1'b0;

      // rst during ROUND
      load_key(C1_KEY);
      @(negedge clk);
      state = C1_CT;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vc0 = valid_count;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_round_out", out, 128'd0);
      check("rst_round_flags", 128'({out_valid, key_ready, busy}), 128'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("rst_round_no_valid", 128'(valid_count - vc0), 128'd0);
      key = C1_KEY;
      state = C1_CT;
      set_key = 1'b1;
      start = 1'b1;
      exp_q.push_back(C1_PT);
      @(negedge clk);
      set_key = 1'b0;
      start = 1'b0;
      wait_valid(vc0 + 1, 30);

      // loopback: model-encrypted random blocks must decrypt back to the plaintext
      rkey = '0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         pt = {$urandom(), $urandom(), $urandom(), $urandom()};
         if (n % 10 == 0) begin
            rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
            key = rkey;
            set_key = 1'b1;
         end
         state = model_encrypt(rkey, pt);
         start = 1'b1;
         exp_q.push_back(pt);
         vc0 = valid_count;
         @(negedge clk);
         set_key = 1'b0;
         start = 1'b0;
         wait_valid(vc0 + 1, 30);
      end

      repeat (5) @(negedge clk);
      check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
